// File: rtl/fifo_core_if.sv
// Write/read/flag bundle between the FIFO driver/monitor and fifo_core.
// FIFO_ERR_FLAGS_EN adds the o_overflow/o_underflow pulse signals.
interface fifo_core_if #(
  parameter int DATA_W = 8
);
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_alm_full;
  logic              o_alm_empty;
  logic              o_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_wren, i_wrdata, i_rden,
    input  o_rddata, o_full, o_alm_full, o_alm_empty, o_empty, o_overflow, o_underflow
  );
  modport slave (
    input  i_wren, i_wrdata, i_rden,
    output o_rddata, o_full, o_alm_full, o_alm_empty, o_empty, o_overflow, o_underflow
  );
`else
  modport master (
    output i_wren, i_wrdata, i_rden,
    input  o_rddata, o_full, o_alm_full, o_alm_empty, o_empty
  );
  modport slave (
    input  i_wren, i_wrdata, i_rden,
    output o_rddata, o_full, o_alm_full, o_alm_empty, o_empty
  );
`endif
endinterface

// File: rtl/fifo_core.sv
// Single-clock FIFO with registered read data and registered status flags.
// Optional feature macro FIFO_ERR_FLAGS_EN: overflow/underflow rejection pulses.
module fifo_core #(
  parameter int DATA_W           = 8,
  parameter int DEPTH            = 16,
  parameter int ALM_FULL_MARGIN  = 2,
  parameter int ALM_EMPTY_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rstn,
  fifo_core_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - ALM_FULL_MARGIN);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALM_EMPTY_MARGIN);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [DATA_W-1:0] rddata_r;
  logic              full_r;
  logic              alm_full_r;
  logic              alm_empty_r;
  logic              empty_r;

  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [CW-1:0]     count_nxt_s;

  // Acceptance uses the registered flags; all flags are derived from the post-edge count.
  always_comb begin
    wr_acc_s    = bus.i_wren & ~full_r;
    rd_acc_s    = bus.i_rden & ~empty_r;
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; not cleared on reset since the pointers make old entries unreachable.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.i_wrdata;
    end
  end

  // Pointers, occupancy, read data and status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      rddata_r    <= '0;
      full_r      <= 1'b0;
      alm_full_r  <= 1'b0;
      alm_empty_r <= 1'b1;
      empty_r     <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        rddata_r <= mem_r[rd_ptr_r];
      end
      count_r     <= count_nxt_s;
      full_r      <= (count_nxt_s == FULL_LVL);
      alm_full_r  <= (count_nxt_s >= AF_LVL);
      alm_empty_r <= (count_nxt_s <= AE_LVL);
      empty_r     <= (count_nxt_s == {CW{1'b0}});
    end
  end

  assign bus.o_rddata    = rddata_r;
  assign bus.o_full      = full_r;
  assign bus.o_alm_full  = alm_full_r;
  assign bus.o_alm_empty = alm_empty_r;
  assign bus.o_empty     = empty_r;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // One-cycle pulses for requests rejected at the previous edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= bus.i_wren & full_r;
      underflow_r <= bus.i_rden & empty_r;
    end
  end

  assign bus.o_overflow  = overflow_r;
  assign bus.o_underflow = underflow_r;
`endif
endmodule
